// File: rtl/ant_tracker.sv
// Pose tracker for the maze ant: turns and forward moves on a bounded grid,
// with hit/escape feedback for the controller and saturating step/bump/stall statistics.
`ifndef HALT
`define HALT 2'd0
`endif
`ifndef RIGHT
`define RIGHT 2'd1
`endif
`ifndef LEFT
`define LEFT 2'd2
`endif
`ifndef FORWARD
`define FORWARD 2'd3
`endif

module ant_tracker #(
  parameter int         X_W         = 6,
  parameter int         Y_W         = 6,
  parameter int         X_MAX       = 31,
  parameter int         Y_MAX       = 31,
  parameter int         X_START     = 0,
  parameter int         Y_START     = 0,
  parameter logic [1:0] HEAD_START  = 2'd0,
  parameter int         EXIT_X      = 31,
  parameter int         EXIT_Y      = 31,
  parameter int         STEP_W      = 16,
  parameter int         STALL_LIMIT = 16,
  parameter logic [1:0] HALT        = `HALT,
  parameter logic [1:0] RIGHT       = `RIGHT,
  parameter logic [1:0] LEFT        = `LEFT,
  parameter logic [1:0] FORWARD     = `FORWARD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        move,
  input  logic              wall_ahead,
  output logic [X_W-1:0]    pos_x,
  output logic [Y_W-1:0]    pos_y,
  output logic [1:0]        heading,
  output logic              hit,
  output logic              escape,
  output logic [STEP_W-1:0] step_cnt,
  output logic [STEP_W-1:0] bump_cnt,
  output logic              stuck
);

  localparam int SC_W = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
  localparam logic [X_W-1:0]  L_X_MAX   = X_W'(X_MAX);
  localparam logic [Y_W-1:0]  L_Y_MAX   = Y_W'(Y_MAX);
  localparam logic [X_W-1:0]  L_X_START = X_W'(X_START);
  localparam logic [Y_W-1:0]  L_Y_START = Y_W'(Y_START);
  localparam logic [X_W-1:0]  L_EXIT_X  = X_W'(EXIT_X);
  localparam logic [Y_W-1:0]  L_EXIT_Y  = Y_W'(EXIT_Y);
  localparam logic [SC_W-1:0] L_LIMIT   = SC_W'(STALL_LIMIT);

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic [1:0]        r_head;
  logic              r_hit;
  logic              r_esc;
  logic [STEP_W-1:0] r_step;
  logic [STEP_W-1:0] r_bump;
  logic [SC_W-1:0]   r_stall;
  logic              r_stuck;

  logic              w_edge;
  logic [X_W-1:0]    w_tx;
  logic [Y_W-1:0]    w_ty;
  logic              w_fwd;
  logic              w_blocked;
  logic              w_adv;
  logic              w_arrive;
  logic [SC_W-1:0]   w_stall_nxt;

  // Target cell and grid-boundary test for the current (pre-move) heading.
  always_comb begin
    w_edge = 1'b0;
    w_tx   = r_x;
    w_ty   = r_y;
    case (r_head)
      2'd0: begin w_edge = (r_y == L_Y_MAX); w_ty = r_y + 1'b1; end
      2'd1: begin w_edge = (r_x == L_X_MAX); w_tx = r_x + 1'b1; end
      2'd2: begin w_edge = (r_y == '0);      w_ty = r_y - 1'b1; end
      default: begin w_edge = (r_x == '0);   w_tx = r_x - 1'b1; end
    endcase
    w_fwd       = (move == FORWARD);
    w_blocked   = wall_ahead | w_edge;
    w_adv       = w_fwd & ~w_blocked;
    w_arrive    = w_adv && (w_tx == L_EXIT_X) && (w_ty == L_EXIT_Y);
    w_stall_nxt = w_adv ? '0 : ((r_stall == L_LIMIT) ? r_stall : r_stall + 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= L_X_START;
      r_y     <= L_Y_START;
      r_head  <= HEAD_START;
      r_hit   <= 1'b0;
      r_esc   <= 1'b0;
      r_step  <= '0;
      r_bump  <= '0;
      r_stall <= '0;
      r_stuck <= 1'b0;
    end else if (!r_esc) begin
      // Once escaped everything holds, so hit stays at the 0 left by the arriving move.
      r_hit   <= w_fwd & w_blocked;
      r_esc   <= w_arrive;
      r_stall <= w_stall_nxt;
      r_stuck <= (w_stall_nxt == L_LIMIT);
      if (move == RIGHT) r_head <= r_head + 2'd1;
      if (move == LEFT)  r_head <= r_head - 2'd1;
      if (w_fwd && w_blocked && (r_bump != '1)) r_bump <= r_bump + 1'b1;
      if (w_adv) begin
        r_x <= w_tx;
        r_y <= w_ty;
        if (r_step != '1) r_step <= r_step + 1'b1;
      end
    end
  end

  assign pos_x    = r_x;
  assign pos_y    = r_y;
  assign heading  = r_head;
  assign hit      = r_hit;
  assign escape   = r_esc;
  assign step_cnt = r_step;
  assign bump_cnt = r_bump;
  assign stuck    = r_stuck;

endmodule

// File: tb/tb_ant_tracker.sv
// Bench for ant_tracker: two configurations, directed scenarios with literal
// expectations, then random moves checked each cycle against a grid-walk model.
module tb_ant_tracker;

  localparam logic [1:0] M_HALT = 2'd0, M_RIGHT = 2'd1, M_LEFT = 2'd2, M_FWD = 2'd3;

  typedef struct packed {
    int x; int y; int h; int hit; int esc; int step; int bump; int stall;
  } mst_t;
  typedef struct packed {
    int xmax; int ymax; int xs; int ys; int hs; int ex; int ey; int smax; int lim;
  } cfg_t;

  // A: default-style config. B: small grid, exit at (2,0), facing E, STEP_W=2, STALL_LIMIT=4.
  localparam cfg_t CFG_A = '{xmax:31, ymax:31, xs:0, ys:0, hs:0, ex:31, ey:31, smax:65535, lim:16};
  localparam cfg_t CFG_B = '{xmax:7, ymax:7, xs:0, ys:0, hs:1, ex:2, ey:0, smax:3, lim:4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [1:0] mv_a = M_HALT, mv_b = M_HALT;
  logic       wl_a = 1'b0, wl_b = 1'b0;

  logic [5:0]  px_a, py_a, px_b, py_b;
  logic [1:0]  hd_a, hd_b;
  logic        hit_a, esc_a, stk_a, hit_b, esc_b, stk_b;
  logic [15:0] st_a, bp_a;
  logic [1:0]  st_b, bp_b;

  ant_tracker #(.X_W(6), .Y_W(6), .X_MAX(31), .Y_MAX(31), .X_START(0), .Y_START(0),
    .HEAD_START(2'd0), .EXIT_X(31), .EXIT_Y(31), .STEP_W(16), .STALL_LIMIT(16),
    .HALT(M_HALT), .RIGHT(M_RIGHT), .LEFT(M_LEFT), .FORWARD(M_FWD)) dut_a (
    .clk(clk), .rst(rst_a), .move(mv_a), .wall_ahead(wl_a), .pos_x(px_a), .pos_y(py_a),
    .heading(hd_a), .hit(hit_a), .escape(esc_a), .step_cnt(st_a), .bump_cnt(bp_a), .stuck(stk_a));

  ant_tracker #(.X_W(6), .Y_W(6), .X_MAX(7), .Y_MAX(7), .X_START(0), .Y_START(0),
    .HEAD_START(2'd1), .EXIT_X(2), .EXIT_Y(0), .STEP_W(2), .STALL_LIMIT(4),
    .HALT(M_HALT), .RIGHT(M_RIGHT), .LEFT(M_LEFT), .FORWARD(M_FWD)) dut_b (
    .clk(clk), .rst(rst_b), .move(mv_b), .wall_ahead(wl_b), .pos_x(px_b), .pos_y(py_b),
    .heading(hd_b), .hit(hit_b), .escape(esc_b), .step_cnt(st_b), .bump_cnt(bp_b), .stuck(stk_b));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: walk one grid step using signed arithmetic and range checks.
  function automatic mst_t model_next(mst_t s, cfg_t c, bit r, int mv, bit w);
    mst_t n = s;
    int dx = 0, dy = 0, tx, ty;
    bit adv = 1'b0;
    if (r) begin
      n = '{x:c.xs, y:c.ys, h:c.hs, hit:0, esc:0, step:0, bump:0, stall:0};
      return n;
    end
    if (s.esc != 0) return n;
    n.hit = 0;
    case (s.h)
      0: dy = 1;
      1: dx = 1;
      2: dy = -1;
      default: dx = -1;
    endcase
    if (mv == int'(M_RIGHT)) n.h = (s.h + 1) % 4;
    if (mv == int'(M_LEFT))  n.h = (s.h + 3) % 4;
    if (mv == int'(M_FWD)) begin
      tx = s.x + dx;
      ty = s.y + dy;
      if (w || tx < 0 || tx > c.xmax || ty < 0 || ty > c.ymax) begin
        n.hit = 1;
        n.bump = (s.bump < c.smax) ? s.bump + 1 : c.smax;
      end else begin
        adv = 1'b1;
        n.x = tx;
        n.y = ty;
        n.step = (s.step < c.smax) ? s.step + 1 : c.smax;
        if (tx == c.ex && ty == c.ey) n.esc = 1;
      end
    end
    n.stall = adv ? 0 : ((s.stall < c.lim) ? s.stall + 1 : c.lim);
    return n;
  endfunction

  mst_t m_a, m_b;
  always @(posedge clk) begin
    m_a = model_next(m_a, CFG_A, rst_a, int'(mv_a), wl_a);
    m_b = model_next(m_b, CFG_B, rst_b, int'(mv_b), wl_b);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("A.pos_x", int'(px_a), m_a.x);
      chk("A.pos_y", int'(py_a), m_a.y);
      chk("A.heading", int'(hd_a), m_a.h);
      chk("A.hit", int'(hit_a), m_a.hit);
      chk("A.escape", int'(esc_a), m_a.esc);
      chk("A.step_cnt", int'(st_a), m_a.step);
      chk("A.bump_cnt", int'(bp_a), m_a.bump);
      chk("A.stuck", int'(stk_a), int'(m_a.stall == CFG_A.lim));
      chk("A.hit_esc_excl", int'(hit_a & esc_a), 0);
      chk("B.pos_x", int'(px_b), m_b.x);
      chk("B.pos_y", int'(py_b), m_b.y);
      chk("B.heading", int'(hd_b), m_b.h);
      chk("B.hit", int'(hit_b), m_b.hit);
      chk("B.escape", int'(esc_b), m_b.esc);
      chk("B.step_cnt", int'(st_b), m_b.step);
      chk("B.bump_cnt", int'(bp_b), m_b.bump);
      chk("B.stuck", int'(stk_b), int'(m_b.stall == CFG_B.lim));
      chk("B.hit_esc_excl", int'(hit_b & esc_b), 0);
    end
  end

  // Drive one cycle on both instances; returns 1ns after the edge so outputs are settled.
  task automatic tick(input bit ra, input logic [1:0] ma, input bit wa,
                      input bit rb, input logic [1:0] mb, input bit wb);
    rst_a = ra; mv_a = ma; wl_a = wa;
    rst_b = rb; mv_b = mb; wl_b = wb;
    @(posedge clk);
    #1;
  endtask

  task automatic ta(input bit ra, input logic [1:0] ma, input bit wa);
    tick(ra, ma, wa, 1'b0, M_HALT, 1'b0);
  endtask

  task automatic tb_(input bit rb, input logic [1:0] mb, input bit wb);
    tick(1'b0, M_HALT, 1'b0, rb, mb, wb);
  endtask

  function automatic logic [1:0] rnd_move();
    if ($urandom_range(0, 9) < 5) return M_FWD;
    return 2'($urandom_range(0, 3));
  endfunction

  initial begin
    // Reset values
    tick(1'b1, M_HALT, 1'b0, 1'b1, M_HALT, 1'b0);
    chk_on = 1'b1;
    chk("rst.A.pos", int'({px_a, py_a}), 0);
    chk("rst.A.heading", int'(hd_a), 0);
    chk("rst.A.flags", int'({hit_a, esc_a, stk_a}), 0);
    chk("rst.A.counts", int'({st_a, bp_a}), 0);
    chk("rst.B.heading", int'(hd_b), 1);

    // Straight run north
    for (int i = 0; i < 3; i++) begin
      ta(1'b0, M_FWD, 1'b0);
      chk("fwd3.hit", int'(hit_a), 0);
    end
    chk("fwd3.pos_x", int'(px_a), 0);
    chk("fwd3.pos_y", int'(py_a), 3);
    chk("fwd3.step", int'(st_a), 3);

    // Turns
    for (int i = 0; i < 4; i++) begin
      ta(1'b0, M_RIGHT, 1'b0);
      chk("right.heading", int'(hd_a), (i + 1) % 4);
    end
    ta(1'b0, M_LEFT, 1'b0);
    chk("left.heading", int'(hd_a), 3);
    chk("turn.pos_y", int'(py_a), 3);

    // Boundary bump facing W at (0,0), then wall bump facing N
    ta(1'b1, M_HALT, 1'b0);
    ta(1'b0, M_LEFT, 1'b0);
    ta(1'b0, M_FWD, 1'b0);
    chk("edge.hit", int'(hit_a), 1);
    chk("edge.pos", int'({px_a, py_a}), 0);
    chk("edge.bump", int'(bp_a), 1);
    ta(1'b0, M_HALT, 1'b0);
    chk("edge.hit_drop", int'(hit_a), 0);
    ta(1'b0, M_RIGHT, 1'b0);
    ta(1'b0, M_FWD, 1'b1);
    chk("wall.hit", int'(hit_a), 1);
    chk("wall.bump", int'(bp_a), 2);
    ta(1'b0, M_FWD, 1'b1);
    chk("wall.hit_b2b", int'(hit_a), 1);

    // Stall on B
    tb_(1'b1, M_HALT, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tb_(1'b0, M_HALT, 1'b0);
      chk("stall.stuck", int'(stk_b), (i == 3) ? 1 : 0);
    end
    tb_(1'b0, M_FWD, 1'b0);
    chk("stall.clear", int'(stk_b), 0);
    chk("stall.pos_x", int'(px_b), 1);

    // Escape on B at (2,0), then frozen
    tb_(1'b0, M_FWD, 1'b0);
    chk("esc.set", int'(esc_b), 1);
    chk("esc.hit", int'(hit_b), 0);
    tb_(1'b0, M_FWD, 1'b0);
    tb_(1'b0, M_RIGHT, 1'b1);
    chk("esc.pos_x", int'(px_b), 2);
    chk("esc.step", int'(st_b), 2);
    chk("esc.heading", int'(hd_b), 1);
    chk("esc.sticky", int'(esc_b), 1);
    tb_(1'b1, M_FWD, 1'b0);
    chk("esc.rst", int'({esc_b, px_b, py_b, st_b}), 0);
    chk("esc.rst_head", int'(hd_b), 1);

    // Saturation with STEP_W=2
    tb_(1'b0, M_LEFT, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tb_(1'b0, M_FWD, 1'b0);
      chk("sat.step", int'(st_b), (i < 3) ? i + 1 : 3);
    end
    chk("sat.pos_y", int'(py_b), 5);

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 299) == 0, rnd_move(), $urandom_range(0, 3) == 0,
           $urandom_range(0, 39) == 0, rnd_move(), $urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
